// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the data_bus round-robin arbiter.
// The optional lock watchdog is enabled with the BUS_ARB_WATCHDOG_EN macro.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int MAX_HOLD_DEF  = 8;
  localparam int WDOG_MULT_DEF = 4;
  localparam int ID_W          = $clog2(N_REQ_DEF);

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set req bit at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  // Scan offsets from farthest to nearest so the requester closest to ptr is written last.
  always_comb begin
    int k;
    any = 1'b0;
    idx = {W{1'b0}};
    k   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k   = (int'(ptr) + i) % N;
      any = any | req[k];
      idx = req[k] ? W'(k) : idx;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin owner arbiter for the shared data_bus with a one-cycle turnaround
// between owners and tenure preemption. Define BUS_ARB_WATCHDOG_EN for the lock watchdog.
module data_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int MAX_HOLD  = MAX_HOLD_DEF,
  parameter int WDOG_MULT = WDOG_MULT_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     bus_busy,
  output logic                     wdog_err
);

  localparam int IDW    = $clog2(N_REQ);
  localparam int HOLD_W = cnt_width(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDW-1:0]    LAST_ID   = IDW'(N_REQ - 1);

  state_t            state_r, state_s;
  logic [N_REQ-1:0]  gnt_r, gnt_s;
  logic [IDW-1:0]    gnt_id_r, gnt_id_s;
  logic [IDW-1:0]    rr_ptr_r, rr_ptr_s;
  logic [IDW-1:0]    pick_idx_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic              busy_r, busy_s;
  logic              pick_any_s;
  logic              owner_req_s, owner_lock_s, others_s;
  logic              preempt_s, wdog_fire_s, release_s;

  rr_pick #(.N(N_REQ), .W(IDW)) u_pick (
    .req (req),
    .ptr (rr_ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  assign owner_req_s  = req[gnt_id_r];
  assign owner_lock_s = lock[gnt_id_r];
  assign others_s     = |(req & ~gnt_r);
  assign preempt_s    = (hold_cnt_r == HOLD_LAST) && others_s && !owner_lock_s;
  assign release_s    = (state_r == GRANT) && (!owner_req_s || preempt_s || wdog_fire_s);

  // Next-state and next-grant logic for the IDLE/GRANT/TURN owner FSM.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    gnt_id_s   = gnt_id_r;
    rr_ptr_s   = rr_ptr_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE, TURN: begin
        if (pick_any_s) begin
          state_s    = GRANT;
          gnt_s      = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          gnt_id_s   = pick_idx_s;
          hold_cnt_s = {HOLD_W{1'b0}};
        end else begin
          state_s = IDLE;
          gnt_s   = {N_REQ{1'b0}};
        end
      end
      GRANT: begin
        if (release_s) begin
          state_s  = TURN;
          gnt_s    = {N_REQ{1'b0}};
          rr_ptr_s = (gnt_id_r == LAST_ID) ? {IDW{1'b0}} : gnt_id_r + IDW'(1);
        end else begin
          hold_cnt_s = (hold_cnt_r == HOLD_LAST) ? hold_cnt_r : hold_cnt_r + HOLD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = {N_REQ{1'b0}};
      end
    endcase
    busy_s = |gnt_s;
  end

  // FSM state and registered grant outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      gnt_r      <= {N_REQ{1'b0}};
      gnt_id_r   <= {IDW{1'b0}};
      rr_ptr_r   <= {IDW{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      gnt_r      <= gnt_s;
      gnt_id_r   <= gnt_id_s;
      rr_ptr_r   <= rr_ptr_s;
      hold_cnt_r <= hold_cnt_s;
      busy_r     <= busy_s;
    end
  end

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int LOCK_LIM = WDOG_MULT * MAX_HOLD;
  localparam int LOCK_W   = cnt_width(LOCK_LIM);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_LIM - 1);

  logic [LOCK_W-1:0] lock_cnt_r;
  logic              wdog_err_r;

  assign wdog_fire_s = owner_lock_s && others_s && (lock_cnt_r == LOCK_LAST);

  // Consecutive locked-cycle counter for the current owner and sticky fault flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_cnt_r <= {LOCK_W{1'b0}};
      wdog_err_r <= 1'b0;
    end else begin
      if ((state_r == GRANT) && !release_s && owner_lock_s) begin
        lock_cnt_r <= (lock_cnt_r == LOCK_LAST) ? lock_cnt_r : lock_cnt_r + LOCK_W'(1);
      end else begin
        lock_cnt_r <= {LOCK_W{1'b0}};
      end
      wdog_err_r <= wdog_err_r | (release_s & wdog_fire_s);
    end
  end

  assign wdog_err = wdog_err_r;
`else
  logic unused_wdog_cfg_s;

  assign unused_wdog_cfg_s = (WDOG_MULT != 32'sd0);
  assign wdog_fire_s       = 1'b0;
  assign wdog_err          = 1'b0;
`endif

  assign gnt      = gnt_r;
  assign gnt_id   = gnt_id_r;
  assign bus_busy = busy_r;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: expected tenures are queued by the stimulus
// and checked by a negedge monitor; dut 0 uses MAX_HOLD=8, dut 1 uses MAX_HOLD=1.
module tb_data_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset_a, reset_b;
  logic [3:0] req_a, lock_a, req_b, lock_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b, wdog_a, wdog_b;

  always #5 clock = ~clock;

  data_bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .WDOG_MULT(4)) dut_a (
    .clock(clock), .reset(reset_a), .req(req_a), .lock(lock_a),
    .gnt(gnt_a), .gnt_id(id_a), .bus_busy(busy_a), .wdog_err(wdog_a)
  );

  data_bus_arbiter #(.N_REQ(4), .MAX_HOLD(1), .WDOG_MULT(4)) dut_b (
    .clock(clock), .reset(reset_b), .req(req_b), .lock(lock_b),
    .gnt(gnt_b), .gnt_id(id_b), .bus_busy(busy_b), .wdog_err(wdog_b)
  );

  typedef struct {
    int         dut;
    logic [3:0] g;
    int         len;
    int         gap;   // dead cycles before this tenure; 0 = not checked
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  logic [3:0] prev_g [2];
  int         len_c [2];
  int         gap_c [2];
  int         gap_s [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int d, input logic [3:0] g, input int len, input int gap);
    exp_t e;
    e.dut = d; e.g = g; e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: per-cycle grant sanity plus tenure length/gap scoreboard.
  always @(negedge clock) begin
    logic [3:0] g;
    logic [1:0] id;
    logic       bz;
    exp_t       e;
    for (int d = 0; d < 2; d++) begin
      g  = (d == 0) ? gnt_a  : gnt_b;
      id = (d == 0) ? id_a   : id_b;
      bz = (d == 0) ? busy_a : busy_b;
      check($sformatf("d%0d_onehot0", d), 32'($onehot0(g)), 32'd1);
      check($sformatf("d%0d_busy_eq_or_gnt", d), 32'(bz), 32'(|g));
      if (g != 4'b0000) check($sformatf("d%0d_gnt_id", d), 32'(id), 32'(idx_of(g)));
      if (g != 4'b0000) begin
        if (prev_g[d] == 4'b0000) begin
          len_c[d] = 1;
          gap_s[d] = gap_c[d];
        end else if (g == prev_g[d]) begin
          len_c[d]++;
        end else begin
          check($sformatf("d%0d_turnaround_before_new_owner", d), 32'(prev_g[d]), 32'd0);
          len_c[d] = 1;
          gap_s[d] = 0;
        end
      end else if (prev_g[d] != 4'b0000) begin
        check($sformatf("d%0d_tenure_expected", d), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("d%0d_tenure_dut", d), 32'(d), 32'(e.dut));
          check($sformatf("d%0d_tenure_gnt", d), 32'(prev_g[d]), 32'(e.g));
          check($sformatf("d%0d_tenure_len_%0h", d, e.g), 32'(len_c[d]), 32'(e.len));
          if (e.gap != 0) check($sformatf("d%0d_gap_before_%0h", d, e.g), 32'(gap_s[d]), 32'(e.gap));
        end
        gap_c[d] = 1;
      end else begin
        gap_c[d]++;
      end
      prev_g[d] = g;
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      prev_g[d] = 4'b0000; len_c[d] = 0; gap_c[d] = 1000; gap_s[d] = 0;
    end
    reset_a = 1'b1; reset_b = 1'b1;
    req_a = 4'b0000; lock_a = 4'b0000; req_b = 4'b0000; lock_b = 4'b0000;
    tick(3);
    check("reset_gnt_a", 32'(gnt_a), 32'd0);
    check("reset_gnt_id_a", 32'(id_a), 32'd0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_wdog_a", 32'(wdog_a), 32'd0);
    check("reset_gnt_b", 32'(gnt_b), 32'd0);

    // Seq 1: req=0101, drop req[0] after three cycles.
    push(0, 4'b0001, 3, 0);
    push(0, 4'b0100, 2, 1);
    reset_a = 1'b0; req_a = 4'b0101;
    tick(1);
    check("first_grant_latency", 32'(gnt_a), 32'h1);
    tick(2);
    req_a = 4'b0100;
    tick(1);
    check("turn_cycle_gnt_zero", 32'(gnt_a), 32'h0);
    tick(1);
    check("grant_after_turn", 32'(gnt_a), 32'h4);
    tick(1);
    req_a = 4'b0000;
    tick(3);

    // Seq 2: full contention, each tenure preempted after MAX_HOLD cycles.
    push(0, 4'b0001, 8, 0);
    push(0, 4'b0010, 8, 1);
    push(0, 4'b0100, 8, 1);
    push(0, 4'b1000, 8, 1);
    push(0, 4'b0001, 4, 1);
    reset_a = 1'b1;
    tick(1);
    reset_a = 1'b0; req_a = 4'b1111;
    tick(40);
    req_a = 4'b0000;
    tick(3);

    // Seq 3: owner 2 locked under full contention for 100 cycles.
`ifdef BUS_ARB_WATCHDOG_EN
    push(0, 4'b0100, 32, 0);
    push(0, 4'b1000, 8, 1);
    push(0, 4'b0001, 8, 1);
    push(0, 4'b0010, 8, 1);
    push(0, 4'b0100, 32, 1);
    push(0, 4'b1000, 8, 1);
`else
    push(0, 4'b0100, 101, 0);
`endif
    reset_a = 1'b1;
    tick(1);
    reset_a = 1'b0; req_a = 4'b0100; lock_a = 4'b0100;
    tick(1);
    req_a = 4'b1111;
    tick(100);
`ifdef BUS_ARB_WATCHDOG_EN
    check("wdog_err_sticky", 32'(wdog_a), 32'd1);
`else
    check("wdog_err_tied_low", 32'(wdog_a), 32'd0);
`endif
    req_a = 4'b0000; lock_a = 4'b0000;
    tick(3);

    // Seq 4: reset mid-tenure of owner 1, then immediate regrant.
    push(0, 4'b0010, 3, 0);
    push(0, 4'b0010, 2, 0);
    reset_a = 1'b1;
    tick(1);
    reset_a = 1'b0; req_a = 4'b0010;
    tick(3);
    reset_a = 1'b1;
    tick(1);
    check("midreset_gnt", 32'(gnt_a), 32'h0);
    check("midreset_gnt_id", 32'(id_a), 32'h0);
    check("midreset_busy", 32'(busy_a), 32'h0);
    check("midreset_wdog", 32'(wdog_a), 32'h0);
    reset_a = 1'b0;
    tick(1);
    check("regrant_after_reset", 32'(gnt_a), 32'h2);
    tick(1);
    req_a = 4'b0000;
    tick(3);

    // Seq 5: requester 3 pulses one cycle every four cycles.
    push(0, 4'b1000, 1, 0);
    push(0, 4'b1000, 1, 3);
    push(0, 4'b1000, 1, 3);
    for (int i = 0; i < 3; i++) begin
      req_a = 4'b1000;
      tick(1);
      req_a = 4'b0000;
      tick(3);
    end
    tick(2);

    // Seq 6: MAX_HOLD=1 with two requesters alternates with a four-cycle period.
    push(1, 4'b0001, 1, 0);
    push(1, 4'b0010, 1, 1);
    push(1, 4'b0001, 1, 1);
    push(1, 4'b0010, 1, 1);
    reset_b = 1'b0; req_b = 4'b0011;
    tick(8);
    req_b = 4'b0000;
    tick(4);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
